// File: rtl/sd_photo_pkg.sv
// Shared types and sizes for the SD photo write/read sequencers.
// The optional SD_WR_TIMEOUT_EN build adds the timeout counter width.
package sd_photo_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    START     = 3'd2,
    WRITE     = 3'd3,
    DONE      = 3'd4
  } photo_state_e;

  localparam int unsigned WORD_CNT_W = 9;
  localparam int unsigned SEC_CNT_W  = 11;
  localparam int unsigned USEDW_W    = 11;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 16;
`ifdef SD_WR_TIMEOUT_EN
  localparam int unsigned TIMEOUT_W  = 26;
`endif

  localparam logic [WORD_CNT_W-1:0] SECTOR_WORDS = 9'd256;

  // Sector command presented to the SD write controller.
  typedef struct packed {
    logic              start_en;
    logic [ADDR_W-1:0] sec_addr;
  } sd_wr_cmd_t;

  function automatic logic [ADDR_W-1:0] slot_base(input logic              sel,
                                                  input logic [ADDR_W-1:0] a0,
                                                  input logic [ADDR_W-1:0] a1);
    return sel ? a1 : a0;
  endfunction

endpackage

// File: rtl/sd_write_photo_if.sv
// Pixel-FIFO / SD-write-controller / status signals of the photo write sequencer.
interface sd_write_photo_if;
  import sd_photo_pkg::*;

  logic                  start;
  logic [USEDW_W-1:0]    fifo_usedw;
  logic [DATA_W-1:0]     fifo_q;
  logic                  fifo_rd_en;
  logic                  wr_busy;
  logic                  wr_req;
  logic                  wr_start_en;
  logic [ADDR_W-1:0]     wr_sec_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start,
    input  fifo_usedw,
    input  fifo_q,
    input  wr_busy,
    input  wr_req,
    output fifo_rd_en,
    output wr_start_en,
    output wr_sec_addr,
    output wr_data,
    output busy,
    output done,
    output err
  );

  modport slave (
    output start,
    output fifo_usedw,
    output fifo_q,
    output wr_busy,
    output wr_req,
    input  fifo_rd_en,
    input  wr_start_en,
    input  wr_sec_addr,
    input  wr_data,
    input  busy,
    input  done,
    input  err
  );

endinterface

// File: rtl/sd_busy_negedge.sv
// Two-flop falling-edge detector on the SD controller busy line.
module sd_busy_negedge (
  input  logic clk,
  input  logic rst_n,
  input  logic busy_i,
  output logic neg_c_o
);

  logic d0_q;
  logic d1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q <= 1'b0;
      d1_q <= 1'b0;
    end else begin
      d0_q <= busy_i;
      d1_q <= d0_q;
    end
  end

  assign neg_c_o = d1_q & ~d0_q;

endmodule

// File: rtl/sd_write_photo.sv
// Drains one RGB565 frame from the pixel FIFO into consecutive SD sectors per start pulse.
// Optional build macro SD_WR_TIMEOUT_EN adds a per-sector busy timeout and sticky err.
module sd_write_photo
  import sd_photo_pkg::*;
#(
  parameter logic [ADDR_W-1:0]    PHOTO_SEC_ADDR0 = 32'd8256,
  parameter logic [ADDR_W-1:0]    PHOTO_SEC_ADDR1 = 32'd9472,
  parameter logic [SEC_CNT_W-1:0] WR_SECTION_NUM  = 11'd1200
`ifdef SD_WR_TIMEOUT_EN
  , parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC   = 26'd50_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  sd_write_photo_if.master  bus
);

  localparam logic [SEC_CNT_W-1:0] SEC_LAST = WR_SECTION_NUM - SEC_CNT_W'(1);

  photo_state_e           state_q, state_d;
  logic                   sel_q, sel_d;
  logic [SEC_CNT_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  sd_wr_cmd_t             cmd_q, cmd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   neg_c;
  logic                   rd_en_c;
  logic                   timeout_c;

  sd_busy_negedge u_busy_neg (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy_i  (bus.wr_busy),
    .neg_c_o (neg_c)
  );

  // Read strobe stays combinational so the word is on fifo_q when the controller samples it.
  assign rd_en_c = (state_q == WRITE) && bus.wr_req && (word_cnt_q < SECTOR_WORDS);

`ifdef SD_WR_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
  logic                 err_q, err_d;

  assign timeout_c = (state_q == WRITE) && bus.wr_busy && !neg_c && (to_cnt_q == TIMEOUT_LAST);

  always_comb begin
    to_cnt_d = to_cnt_q;
    err_d    = err_q | timeout_c;
    if ((state_q != WRITE) || neg_c || timeout_c) begin
      to_cnt_d = '0;
    end else if (bus.wr_busy) begin
      to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout_c = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    sec_cnt_d        = sec_cnt_q;
    word_cnt_d       = word_cnt_q;
    cmd_d            = cmd_q;
    cmd_d.start_en   = 1'b0;
    busy_d           = busy_q;
    done_d           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cmd_d.sec_addr = slot_base(sel_q, PHOTO_SEC_ADDR0, PHOTO_SEC_ADDR1);
          sel_d          = ~sel_q;
          busy_d         = 1'b1;
          state_d        = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // A full sector must already be buffered so the controller can never underrun.
        if (bus.fifo_usedw >= USEDW_W'(SECTOR_WORDS)) begin
          cmd_d.start_en = 1'b1;
          state_d        = START;
        end
      end
      START: begin
        word_cnt_d = '0;
        state_d    = WRITE;
      end
      WRITE: begin
        if (rd_en_c) begin
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
        end
        if (neg_c) begin
          cmd_d.sec_addr = cmd_q.sec_addr + ADDR_W'(1);
          if (sec_cnt_q == SEC_LAST) begin
            sec_cnt_d = '0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = DONE;
          end else begin
            sec_cnt_d = sec_cnt_q + SEC_CNT_W'(1);
            state_d   = WAIT_DATA;
          end
        end else if (timeout_c) begin
          sec_cnt_d  = '0;
          word_cnt_d = '0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      sec_cnt_q  <= '0;
      word_cnt_q <= '0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sec_cnt_q  <= sec_cnt_d;
      word_cnt_q <= word_cnt_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.fifo_rd_en  = rd_en_c;
  assign bus.wr_data     = (state_q == WRITE) ? bus.fifo_q : '0;
  assign bus.wr_start_en = cmd_q.start_en;
  assign bus.wr_sec_addr = cmd_q.sec_addr;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
